// File: rtl/usb_in_ep_ctrl.sv
// Interrupt IN endpoint 1 transaction sequencer: decodes IN tokens, answers with
// DATA0/DATA1 + CRC16 or NAK, then tracks the host handshake and the data toggle.
module usb_in_ep_ctrl #(
    parameter int unsigned REPORT_BYTES = 4,
    parameter int unsigned ACK_TIMEOUT  = 72,
    parameter int unsigned END_HOLD     = 8
) (
    input  logic                      clk_48m,
    input  logic                      rst_n,
    input  logic [6:0]                dev_addr,
    input  logic                      toggle_clr,
    input  logic [3:0]                rx_pid,
    input  logic                      rx_pid_valid,
    input  logic [7:0]                rx_data,
    input  logic                      rx_data_valid,
    input  logic                      rx_pkt_end,
    output logic [3:0]                tx_pid,
    output logic [7:0]                tx_data,
    output logic                      tx_data_valid,
    output logic                      tx_pkt_start,
    output logic                      tx_pkt_end,
    input  logic                      tx_ready,
    input  logic                      rpt_valid,
    input  logic [8*REPORT_BYTES-1:0] rpt_data,
    output logic                      rpt_taken,
    output logic                      data_toggle,
    output logic                      busy
);

    localparam int unsigned IdxW = (REPORT_BYTES > 1) ? $clog2(REPORT_BYTES) : 1;
    localparam int unsigned EndW = $clog2(END_HOLD + 1);
    localparam int unsigned ToW  = $clog2(ACK_TIMEOUT + 1);

    localparam logic [IdxW-1:0] IdxLast = IdxW'(REPORT_BYTES - 1);
    localparam logic [EndW-1:0] EndLast = EndW'(END_HOLD - 1);
    localparam logic [ToW-1:0]  ToLast  = ToW'(ACK_TIMEOUT - 1);

    localparam logic [3:0] PidIn    = 4'b1001;
    localparam logic [3:0] PidAck   = 4'b0010;
    localparam logic [3:0] PidData0 = 4'b0011;
    localparam logic [3:0] PidData1 = 4'b1011;
    localparam logic [3:0] PidNak   = 4'b1010;

    typedef enum logic [2:0] {
        StIdle, StToken, StTokEnd, StTxPid, StTxBytes, StTxCrc, StTxEnd, StWaitHs
    } state_e;

    // Reflected CRC16 (poly 0x8005 as 0xA001), data bits taken LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ 16'hA001;
            else                c = c >> 1;
        end
        return c;
    endfunction

    state_e          state_q, state_d;
    logic [7:0]      tok_b0_q, tok_b0_d;
    logic [2:0]      tok_b1_q, tok_b1_d;
    logic            tok_cnt_q, tok_cnt_d;
    logic [7:0]      hold_q [REPORT_BYTES];
    logic [7:0]      hold_d [REPORT_BYTES];
    logic            full_q, full_d;
    logic            toggle_q, toggle_d;
    logic [15:0]     crc_q, crc_d;
    logic [15:0]     crc_fold;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            crc_hi_q, crc_hi_d;
    logic [EndW-1:0] end_cnt_q, end_cnt_d;
    logic [ToW-1:0]  to_cnt_q, to_cnt_d;
    logic [3:0]      tx_pid_q, tx_pid_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_dv_q, tx_dv_d;
    logic            tx_start_q, tx_start_d;
    logic            tx_end_q, tx_end_d;
    logic            taken_q, taken_d;

    assign crc_fold = crc16_byte(crc_q, tx_data_q);

    always_comb begin
        state_d    = state_q;
        tok_b0_d   = tok_b0_q;
        tok_b1_d   = tok_b1_q;
        tok_cnt_d  = tok_cnt_q;
        hold_d     = hold_q;
        full_d     = full_q;
        toggle_d   = toggle_q;
        crc_d      = crc_q;
        idx_d      = idx_q;
        crc_hi_d   = crc_hi_q;
        end_cnt_d  = end_cnt_q;
        to_cnt_d   = to_cnt_q;
        tx_pid_d   = tx_pid_q;
        tx_data_d  = tx_data_q;
        tx_dv_d    = tx_dv_q;
        tx_start_d = tx_start_q;
        tx_end_d   = tx_end_q;
        taken_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_pid_valid && rx_pid == PidIn) begin
                    state_d   = StToken;
                    tok_cnt_d = 1'b0;
                end
            end
            StToken, StTokEnd: begin
                if (rx_pid_valid) begin
                    state_d   = (rx_pid == PidIn) ? StToken : StIdle;
                    tok_cnt_d = 1'b0;
                end else if (rx_pkt_end) begin
                    if (state_q == StTokEnd && tok_b0_q[6:0] == dev_addr &&
                        {tok_b1_q, tok_b0_q[7]} == 4'd1) begin
                        state_d    = StTxPid;
                        crc_d      = 16'hFFFF;
                        tx_start_d = 1'b1;
                        // Latch only into an empty register so retries resend the same report.
                        if (!full_q && rpt_valid) begin
                            for (int i = 0; i < REPORT_BYTES; i++) hold_d[i] = rpt_data[8*i +: 8];
                            full_d = 1'b1;
                        end
                        tx_pid_d = full_d ? (toggle_q ? PidData1 : PidData0) : PidNak;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (rx_data_valid && state_q == StToken) begin
                    if (!tok_cnt_q) begin
                        tok_b0_d  = rx_data;
                        tok_cnt_d = 1'b1;
                    end else begin
                        tok_b1_d = rx_data[2:0];
                        state_d  = StTokEnd;
                    end
                end
            end
            StTxPid: begin
                if (tx_ready) begin
                    tx_start_d = 1'b0;
                    if (full_q) begin
                        state_d   = StTxBytes;
                        idx_d     = '0;
                        tx_data_d = hold_q[0];
                        tx_dv_d   = 1'b1;
                    end else begin
                        state_d   = StTxEnd;
                        end_cnt_d = '0;
                        tx_end_d  = 1'b1;
                    end
                end
            end
            StTxBytes: begin
                if (tx_ready) begin
                    crc_d = crc_fold;
                    if (idx_q == IdxLast) begin
                        state_d   = StTxCrc;
                        crc_hi_d  = 1'b0;
                        tx_data_d = ~crc_fold[7:0];
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        tx_data_d = hold_q[idx_d];
                    end
                end
            end
            StTxCrc: begin
                if (tx_ready) begin
                    if (!crc_hi_q) begin
                        crc_hi_d  = 1'b1;
                        tx_data_d = ~crc_q[15:8];
                    end else begin
                        state_d   = StTxEnd;
                        tx_dv_d   = 1'b0;
                        tx_end_d  = 1'b1;
                        end_cnt_d = '0;
                    end
                end
            end
            StTxEnd: begin
                if (end_cnt_q == EndLast) begin
                    tx_end_d = 1'b0;
                    to_cnt_d = '0;
                    state_d  = full_q ? StWaitHs : StIdle;
                end else begin
                    end_cnt_d = end_cnt_q + 1'b1;
                end
            end
            StWaitHs: begin
                if (rx_pid_valid) begin
                    state_d = StIdle;
                    if (rx_pid == PidAck) begin
                        toggle_d = ~toggle_q;
                        full_d   = 1'b0;
                        taken_d  = 1'b1;
                    end
                end else if (to_cnt_q == ToLast) begin
                    state_d = StIdle;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (toggle_clr) toggle_d = 1'b0;
    end

    always_ff @(posedge clk_48m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            tok_b0_q   <= '0;
            tok_b1_q   <= '0;
            tok_cnt_q  <= 1'b0;
            for (int i = 0; i < REPORT_BYTES; i++) hold_q[i] <= '0;
            full_q     <= 1'b0;
            toggle_q   <= 1'b0;
            crc_q      <= 16'hFFFF;
            idx_q      <= '0;
            crc_hi_q   <= 1'b0;
            end_cnt_q  <= '0;
            to_cnt_q   <= '0;
            tx_pid_q   <= '0;
            tx_data_q  <= '0;
            tx_dv_q    <= 1'b0;
            tx_start_q <= 1'b0;
            tx_end_q   <= 1'b0;
            taken_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tok_b0_q   <= tok_b0_d;
            tok_b1_q   <= tok_b1_d;
            tok_cnt_q  <= tok_cnt_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
            toggle_q   <= toggle_d;
            crc_q      <= crc_d;
            idx_q      <= idx_d;
            crc_hi_q   <= crc_hi_d;
            end_cnt_q  <= end_cnt_d;
            to_cnt_q   <= to_cnt_d;
            tx_pid_q   <= tx_pid_d;
            tx_data_q  <= tx_data_d;
            tx_dv_q    <= tx_dv_d;
            tx_start_q <= tx_start_d;
            tx_end_q   <= tx_end_d;
            taken_q    <= taken_d;
        end
    end

    assign tx_pid        = tx_pid_q;
    assign tx_data       = tx_data_q;
    assign tx_data_valid = tx_dv_q;
    assign tx_pkt_start  = tx_start_q;
    assign tx_pkt_end    = tx_end_q;
    assign rpt_taken     = taken_q;
    assign data_toggle   = toggle_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_usb_in_ep_ctrl.sv
// Scoreboard bench for usb_in_ep_ctrl: a 4-byte instance (addr 5) and a 9-byte instance (addr 9)
// share the receive bus; transmitted PIDs/bytes are checked against a queue of expected events.
module tb_usb_in_ep_ctrl;

    localparam logic [3:0] PidIn    = 4'b1001;
    localparam logic [3:0] PidAck   = 4'b0010;
    localparam logic [3:0] PidData0 = 4'b0011;
    localparam logic [3:0] PidData1 = 4'b1011;
    localparam logic [3:0] PidNak   = 4'b1010;

    typedef struct packed {
        logic       inst;
        logic       kind;  // 0 = PID handshake, 1 = data byte handshake
        logic [7:0] val;
    } ev_t;

    logic clk_48m = 1'b0;
    logic rst_n;
    logic toggle_clr;
    logic [3:0] rx_pid;
    logic rx_pid_valid, rx_data_valid, rx_pkt_end;
    logic [7:0] rx_data;

    logic [3:0] tx_pid_a, tx_pid_b;
    logic [7:0] tx_data_a, tx_data_b;
    logic tx_data_valid_a, tx_pkt_start_a, tx_pkt_end_a, tx_ready_a;
    logic tx_data_valid_b, tx_pkt_start_b, tx_pkt_end_b, tx_ready_b;
    logic rpt_valid_a, rpt_valid_b, rpt_taken_a, rpt_taken_b;
    logic data_toggle_a, data_toggle_b, busy_a, busy_b;
    logic [31:0] rpt_data_a;
    logic [71:0] rpt_data_b;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  gap_a = 0;
    int  gap_b = 0;

    always #10 clk_48m = ~clk_48m;

    usb_in_ep_ctrl #(.REPORT_BYTES(4), .ACK_TIMEOUT(72), .END_HOLD(8)) u_dut_a (
        .clk_48m(clk_48m), .rst_n(rst_n), .dev_addr(7'd5), .toggle_clr(toggle_clr),
        .rx_pid(rx_pid), .rx_pid_valid(rx_pid_valid), .rx_data(rx_data),
        .rx_data_valid(rx_data_valid), .rx_pkt_end(rx_pkt_end),
        .tx_pid(tx_pid_a), .tx_data(tx_data_a), .tx_data_valid(tx_data_valid_a),
        .tx_pkt_start(tx_pkt_start_a), .tx_pkt_end(tx_pkt_end_a), .tx_ready(tx_ready_a),
        .rpt_valid(rpt_valid_a), .rpt_data(rpt_data_a), .rpt_taken(rpt_taken_a),
        .data_toggle(data_toggle_a), .busy(busy_a)
    );

    usb_in_ep_ctrl #(.REPORT_BYTES(9), .ACK_TIMEOUT(72), .END_HOLD(8)) u_dut_b (
        .clk_48m(clk_48m), .rst_n(rst_n), .dev_addr(7'd9), .toggle_clr(toggle_clr),
        .rx_pid(rx_pid), .rx_pid_valid(rx_pid_valid), .rx_data(rx_data),
        .rx_data_valid(rx_data_valid), .rx_pkt_end(rx_pkt_end),
        .tx_pid(tx_pid_b), .tx_data(tx_data_b), .tx_data_valid(tx_data_valid_b),
        .tx_pkt_start(tx_pkt_start_b), .tx_pkt_end(tx_pkt_end_b), .tx_ready(tx_ready_b),
        .rpt_valid(rpt_valid_b), .rpt_data(rpt_data_b), .rpt_taken(rpt_taken_b),
        .data_toggle(data_toggle_b), .busy(busy_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_check(input ev_t got);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: got inst%0d kind%0d %02h, expected nothing",
                     got.inst, got.kind, got.val);
        end else begin
            e = exp_q.pop_front();
            if (e !== got) begin
                n_err++;
                $display("FAIL sb_event: got inst%0d kind%0d %02h, expected inst%0d kind%0d %02h",
                         got.inst, got.kind, got.val, e.inst, e.kind, e.val);
            end
        end
    endtask

    function automatic ev_t mk(input logic inst, input logic kind, input logic [7:0] val);
        ev_t e;
        e.inst = inst;
        e.kind = kind;
        e.val  = val;
        return e;
    endfunction

    // Expected transmit sequence: PID, payload bytes, optionally the USB CRC16 of the payload.
    task automatic push_pkt(input logic inst, input logic [3:0] pid, input logic [127:0] payload,
                            input int nbytes, input bit add_crc);
        logic [15:0] crc;
        logic [7:0]  b;
        logic        fb;
        crc = 16'hFFFF;
        exp_q.push_back(mk(inst, 1'b0, {4'h0, pid}));
        for (int i = 0; i < nbytes; i++) begin
            b = payload[8*i +: 8];
            exp_q.push_back(mk(inst, 1'b1, b));
            for (int j = 0; j < 8; j++) begin
                fb  = crc[0] ^ b[j];
                crc = {1'b0, crc[15:1]};
                if (fb) crc = crc ^ 16'hA001;
            end
        end
        crc = ~crc;
        if (add_crc) begin
            exp_q.push_back(mk(inst, 1'b1, crc[7:0]));
            exp_q.push_back(mk(inst, 1'b1, crc[15:8]));
        end
    endtask

    always @(negedge clk_48m) begin
        if (rst_n) begin
            if (tx_ready_a && tx_pkt_start_a)  sb_check(mk(1'b0, 1'b0, {4'h0, tx_pid_a}));
            if (tx_ready_a && tx_data_valid_a) sb_check(mk(1'b0, 1'b1, tx_data_a));
            if (tx_ready_b && tx_pkt_start_b)  sb_check(mk(1'b1, 1'b0, {4'h0, tx_pid_b}));
            if (tx_ready_b && tx_data_valid_b) sb_check(mk(1'b1, 1'b1, tx_data_b));
        end
    end

    // Transmitter models: a one-clock tx_ready every third clock while a request is pending.
    initial begin
        tx_ready_a = 1'b0;
        forever begin
            @(posedge clk_48m); #1;
            if (tx_ready_a || !rst_n) begin
                tx_ready_a = 1'b0;
                gap_a = 0;
            end else if (tx_pkt_start_a || tx_data_valid_a) begin
                if (gap_a == 2) begin tx_ready_a = 1'b1; gap_a = 0; end
                else gap_a++;
            end else gap_a = 0;
        end
    end

    initial begin
        tx_ready_b = 1'b0;
        forever begin
            @(posedge clk_48m); #1;
            if (tx_ready_b || !rst_n) begin
                tx_ready_b = 1'b0;
                gap_b = 0;
            end else if (tx_pkt_start_b || tx_data_valid_b) begin
                if (gap_b == 2) begin tx_ready_b = 1'b1; gap_b = 0; end
                else gap_b++;
            end else gap_b = 0;
        end
    end

    task automatic tick();
        @(posedge clk_48m); #1;
    endtask

    task automatic send_pid(input logic [3:0] p);
        rx_pid = p; rx_pid_valid = 1'b1; tick(); rx_pid_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_data_valid = 1'b1; tick(); rx_data_valid = 1'b0;
    endtask

    task automatic send_eop();
        rx_pkt_end = 1'b1; tick(); rx_pkt_end = 1'b0;
    endtask

    task automatic token(input logic [6:0] addr, input logic [3:0] endp);
        send_pid(PidIn);
        send_byte({endp[0], addr});
        send_byte({5'b10110, endp[3:1]});
        send_eop();
    endtask

    // Returns one clock after tx_pkt_end falls.
    task automatic wait_done(input bit inst, input string name);
        int n;
        n = 0;
        while (!(inst ? tx_pkt_end_b : tx_pkt_end_a) && n < 400) begin tick(); n++; end
        while ((inst ? tx_pkt_end_b : tx_pkt_end_a) && n < 400) begin tick(); n++; end
        if (n >= 400) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: packet end not seen within 400 clocks", name);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; toggle_clr = 1'b0;
        rx_pid = '0; rx_pid_valid = 1'b0; rx_data = '0; rx_data_valid = 1'b0; rx_pkt_end = 1'b0;
        rpt_valid_a = 1'b0; rpt_data_a = '0; rpt_valid_b = 1'b0; rpt_data_b = '0;
        repeat (3) tick();
        chk("reset_outs_a", {tx_pid_a, tx_data_a, tx_data_valid_a, tx_pkt_start_a, tx_pkt_end_a,
                             rpt_taken_a, data_toggle_a, busy_a}, 32'h0);
        chk("reset_outs_b", {tx_pid_b, tx_data_b, tx_data_valid_b, tx_pkt_start_b, tx_pkt_end_b,
                             rpt_taken_b, data_toggle_b, busy_b}, 32'h0);
        rst_n = 1'b1;
        repeat (2) tick();

        // No report pending: NAK only.
        push_pkt(1'b0, PidNak, '0, 0, 1'b0);
        token(7'd5, 4'd1);
        chk("nak_start_latency", tx_pkt_start_a, 1);
        wait_done(1'b0, "nak_done");
        chk("nak_idle", busy_a, 0);
        chk("nak_toggle", data_toggle_a, 0);

        token(7'd6, 4'd1);
        chk("addr_mismatch", {tx_pkt_start_a, busy_a}, 0);
        token(7'd5, 4'd2);
        chk("endp_mismatch", {tx_pkt_start_a, busy_a}, 0);

        send_pid(PidIn);
        send_byte(8'h85);
        chk("trunc_busy", busy_a, 1);
        send_eop();
        chk("trunc_idle", {tx_pkt_start_a, busy_a}, 0);

        // Report 01 02 03 04, never acknowledged.
        rpt_data_a = 32'h04030201; rpt_valid_a = 1'b1;
        push_pkt(1'b0, PidData0, {96'h0, 32'h04030201}, 4, 1'b1);
        token(7'd5, 4'd1);
        chk("data_start_latency", tx_pkt_start_a, 1);
        chk("data0_pid", tx_pid_a, PidData0);
        wait_done(1'b0, "data_done");
        n = 0;
        while (busy_a && n < 200) begin tick(); n++; end
        chk("ack_timeout_clocks", n, 72);
        chk("timeout_toggle", data_toggle_a, 0);

        // Retry must resend the held report even though rpt_data moved on.
        rpt_data_a = 32'hAABBCCDD;
        push_pkt(1'b0, PidData0, {96'h0, 32'h04030201}, 4, 1'b1);
        token(7'd5, 4'd1);
        chk("resend_pid", tx_pid_a, PidData0);
        wait_done(1'b0, "resend_done");
        repeat (39) tick();
        chk("wait_hs_busy", busy_a, 1);
        send_pid(PidAck);
        chk("ack_taken", rpt_taken_a, 1);
        chk("ack_toggle", data_toggle_a, 1);
        chk("ack_idle", busy_a, 0);
        tick();
        chk("taken_pulse", rpt_taken_a, 0);

        // Fresh report goes out as DATA1; toggle_clr with the ACK wins.
        push_pkt(1'b0, PidData1, {96'h0, 32'hAABBCCDD}, 4, 1'b1);
        token(7'd5, 4'd1);
        chk("data1_pid", tx_pid_a, PidData1);
        wait_done(1'b0, "data1_done");
        repeat (5) tick();
        toggle_clr = 1'b1;
        send_pid(PidAck);
        toggle_clr = 1'b0;
        chk("clr_vs_ack_toggle", data_toggle_a, 0);
        chk("clr_vs_ack_taken", rpt_taken_a, 1);

        // Asynchronous reset in the middle of the payload.
        rpt_data_a = 32'h44332211;
        push_pkt(1'b0, PidData0, {96'h0, 32'h44332211}, 4, 1'b1);
        token(7'd5, 4'd1);
        n = 0;
        while (!tx_data_valid_a && n < 50) begin tick(); n++; end
        repeat (4) tick();
        chk("mid_payload", tx_data_valid_a, 1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outs", {tx_pid_a, tx_data_a, tx_data_valid_a, tx_pkt_start_a,
                                    tx_pkt_end_a, rpt_taken_a, data_toggle_a, busy_a}, 32'h0);
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_idle", busy_a, 0);
        // Held report was dropped by reset: with no new report the answer is NAK.
        rpt_valid_a = 1'b0;
        push_pkt(1'b0, PidNak, '0, 0, 1'b0);
        token(7'd5, 4'd1);
        wait_done(1'b0, "post_reset_nak");
        chk("post_reset_nak_idle", busy_a, 0);

        // Nine-byte report "123456789": CRC bytes C8 then B4.
        rpt_data_b = 72'h393837363534333231; rpt_valid_b = 1'b1;
        push_pkt(1'b1, PidData0, {56'h0, 72'h393837363534333231}, 9, 1'b0);
        exp_q.push_back(mk(1'b1, 1'b1, 8'hC8));
        exp_q.push_back(mk(1'b1, 1'b1, 8'hB4));
        token(7'd9, 4'd1);
        chk("b_start_latency", tx_pkt_start_b, 1);
        chk("a_ignores_addr9", tx_pkt_start_a, 0);
        wait_done(1'b1, "b_done");
        send_pid(PidAck);
        chk("b_taken", rpt_taken_b, 1);
        chk("b_toggle", data_toggle_b, 1);

        repeat (4) tick();
        chk("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
